// File: rtl/rgb_frame_capture.sv
// -----------------------------------------------------------------------------
// rgb_frame_capture
//
// Captures one RGB frame from a valid/ready pixel stream into a flat frame
// buffer, row-major at address y*W + x. The address is a plain incrementing
// counter, so no multiplier is needed. Stream framing is checked along the
// way: a mid-frame SOF, a misplaced EOL and an illegal frame size are each
// reported on a sticky flag. The downstream matrix-compare stage may read the
// buffer once frame_done has pulsed.
//
// Optional feature macro: RGB_FRAME_CAPTURE_CHECKSUM_EN
//   When defined, per-channel running sums (sum_r, sum_g, sum_b) of every
//   written pixel are added as outputs.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse arming a capture (ignored while busy)
//   cfg_width/height    frame size, sampled on start (legal 1..W_MAX / H_MAX)
//   s_valid/s_ready     pixel stream handshake (s_ready is registered)
//   s_data              pixel {R,G,B}, R in the MSBs
//   s_sof / s_eol       first pixel of frame / last pixel of line
//   mem_we/addr/wdata   registered frame-buffer write port
//   busy                high from accepted start until DONE is left
//   frame_done          one-cycle completion pulse, one cycle after last write
//   err_sof/line/cfg    sticky framing / configuration error flags
//   pix_cnt             pixels written in the current or last frame
//   sum_r/g/b           (macro only) channel sums over written pixels
// -----------------------------------------------------------------------------
module rgb_frame_capture #(
    parameter int CW    = 8,
    parameter int W_MAX = 640,
    parameter int H_MAX = 480,
    parameter int AW    = $clog2(W_MAX * H_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       cfg_width,
    input  logic [15:0]       cfg_height,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3*CW-1:0]   s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [3*CW-1:0]   mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              err_sof,
    output logic              err_line,
    output logic              err_cfg,
    output logic [AW:0]       pix_cnt
`ifdef RGB_FRAME_CAPTURE_CHECKSUM_EN
    ,
    output logic [CW+AW-1:0]  sum_r,
    output logic [CW+AW-1:0]  sum_g,
    output logic [CW+AW-1:0]  sum_b
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [15:0] W_MAX_C  = 16'(W_MAX);
    localparam logic [15:0] H_MAX_C  = 16'(H_MAX);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   PIX_ONE  = (AW + 1)'(1);

    state_t        state;
    state_t        state_nxt;

    logic [15:0]   w_q;
    logic [15:0]   h_q;
    logic [15:0]   x_q;
    logic [15:0]   y_q;
    logic [AW-1:0] addr_q;

    logic          fire;
    logic          write_fire;
    logic          x_last;
    logic          y_last;
    logic          frame_last;
    logic          cfg_ok;
    logic          start_ok;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt  = state;
        fire       = s_valid && s_ready;
        write_fire = 1'b0;
        start_ok   = 1'b0;
        x_last     = (x_q == w_q - 16'd1);
        y_last     = (y_q == h_q - 16'd1);
        cfg_ok     = (cfg_width != 16'd0) && (cfg_height != 16'd0) &&
                     (cfg_width <= W_MAX_C) && (cfg_height <= H_MAX_C);

        case (state)
            IDLE: begin
                if (start && cfg_ok) begin
                    start_ok  = 1'b1;
                    state_nxt = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                // Pixels ahead of the SOF are dropped silently.
                if (fire && s_sof) begin
                    write_fire = 1'b1;
                end
            end
            CAPTURE: begin
                if (fire) begin
                    write_fire = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A 1x1 frame completes on its SOF pixel, straight from WAIT_SOF.
        frame_last = write_fire && x_last && y_last;
        if (write_fire) begin
            state_nxt = frame_last ? DONE : CAPTURE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err_sof    <= 1'b0;
            err_line   <= 1'b0;
            err_cfg    <= 1'b0;
            pix_cnt    <= '0;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
        end else begin
            // Decoding next state keeps s_ready and busy exact functions of
            // the current state, with no combinational path from the inputs.
            s_ready    <= (state_nxt == WAIT_SOF) || (state_nxt == CAPTURE);
            busy       <= (state_nxt != IDLE);
            frame_done <= (state == DONE);
            mem_we     <= write_fire;

            if (state == IDLE && start) begin
                w_q <= cfg_width;
                h_q <= cfg_height;
                if (!start_ok) begin
                    err_cfg <= 1'b1;
                end else begin
                    err_cfg  <= 1'b0;
                    err_sof  <= 1'b0;
                    err_line <= 1'b0;
                    pix_cnt  <= '0;
                    x_q      <= '0;
                    y_q      <= '0;
                    addr_q   <= '0;
                end
            end

            if (write_fire) begin
                mem_addr  <= addr_q;
                mem_wdata <= s_data;
                addr_q    <= addr_q + ADDR_ONE;
                pix_cnt   <= pix_cnt + PIX_ONE;
                // Line position follows the configured width, never s_eol.
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + 16'd1;
                end else begin
                    x_q <= x_q + 16'd1;
                end
                if (s_eol != x_last) begin
                    err_line <= 1'b1;
                end
            end

            if (state == CAPTURE && fire && s_sof) begin
                err_sof <= 1'b1;
            end
        end
    end

`ifdef RGB_FRAME_CAPTURE_CHECKSUM_EN
    localparam int SW = CW + AW;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (start_ok) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (write_fire) begin
            sum_r <= sum_r + SW'(s_data[3*CW-1 -: CW]);
            sum_g <= sum_g + SW'(s_data[2*CW-1 -: CW]);
            sum_b <= sum_b + SW'(s_data[CW-1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_rgb_frame_capture.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rgb_frame_capture. A frame is described as a list of
// pixels; the expected buffer image, error flags, counts and channel sums are
// computed from that list with plain arithmetic and compared with what the
// write port and status outputs show.
// -----------------------------------------------------------------------------
module tb_rgb_frame_capture;

    localparam int CW    = 8;
    localparam int W_MAX = 640;
    localparam int H_MAX = 480;
    localparam int AW    = $clog2(W_MAX * H_MAX);
    localparam int DW    = 3 * CW;
    localparam int SW    = CW + AW;
    localparam int LOG_N = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     cfg_width;
    logic [15:0]     cfg_height;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            s_sof;
    logic            s_eol;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            busy;
    logic            frame_done;
    logic            err_sof;
    logic            err_line;
    logic            err_cfg;
    logic [AW:0]     pix_cnt;
`ifdef RGB_FRAME_CAPTURE_CHECKSUM_EN
    logic [SW-1:0]   sum_r;
    logic [SW-1:0]   sum_g;
    logic [SW-1:0]   sum_b;
`endif

    rgb_frame_capture #(
        .CW(CW), .W_MAX(W_MAX), .H_MAX(H_MAX), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .frame_done(frame_done),
        .err_sof(err_sof), .err_line(err_line), .err_cfg(err_cfg),
        .pix_cnt(pix_cnt)
`ifdef RGB_FRAME_CAPTURE_CHECKSUM_EN
        , .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            sof;
        bit            eol;
    } px_t;

    px_t           stream [$];
    logic [DW-1:0] exp_px [$];
    bit            exp_line;
    bit            exp_sof;

    int n_checks = 0;
    int n_err    = 0;

    // Write-port and frame_done log, filled on the falling edge.
    int               cyc      = 0;
    int               n_wr     = 0;
    int               fd_total = 0;
    int               fd_cyc   = 0;
    logic [AW+DW-1:0] wr_key [LOG_N];
    int               wr_cyc [LOG_N];

    int wr_base;
    int fd_base;
    int ready_viol;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we && n_wr < LOG_N) begin
            wr_key[n_wr] = {mem_addr, mem_wdata};
            wr_cyc[n_wr] = cyc;
            n_wr = n_wr + 1;
        end
        if (frame_done) begin
            fd_total = fd_total + 1;
            fd_cyc   = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Builds the stream (junk pixels, then a WxH frame) and the expected image.
    // bad_eol_k flips the EOL marker of frame pixel k; extra_sof_k adds an SOF.
    task automatic build_stream(input int w, input int h, input int junk,
                                input int bad_eol_k, input int extra_sof_k,
                                input bit idx_data);
        px_t p;
        bit  line_end;
        stream.delete();
        exp_px.delete();
        exp_line = 1'b0;
        exp_sof  = 1'b0;
        for (int j = 0; j < junk; j++) begin
            p.d   = DW'($urandom);
            p.sof = 1'b0;
            p.eol = 1'($urandom_range(1));
            stream.push_back(p);
        end
        for (int k = 0; k < w * h; k++) begin
            line_end = ((k % w) == w - 1);
            p.d   = idx_data ? DW'(k) : DW'($urandom);
            p.sof = (k == 0) || (k == extra_sof_k);
            p.eol = line_end ^ (k == bad_eol_k);
            stream.push_back(p);
            exp_px.push_back(p.d);
            if (p.eol != line_end) exp_line = 1'b1;
            if (k > 0 && p.sof)    exp_sof  = 1'b1;
        end
    endtask

    task automatic pulse_start(input int w, input int h);
        @(negedge clk);
        start      = 1'b1;
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents the stream, counting transfers; s_ready must stay high while
    // the frame is still outstanding. Optionally holds start high to show it
    // is ignored mid-capture. Enters and leaves on a falling edge.
    task automatic drive_stream(input int gap, input int max_px, input bit poke,
                                output int sent);
        int   budget;
        logic rdy;
        budget     = 8000;
        sent       = 0;
        ready_viol = 0;
        while (sent < stream.size() && sent < max_px && budget > 0) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = stream[sent].d;
                s_sof   = stream[sent].sof;
                s_eol   = stream[sent].eol;
            end
            if (poke) begin
                start      = 1'b1;
                cfg_width  = 16'd2;
                cfg_height = 16'd2;
            end
            rdy = s_ready;
            if (rdy !== 1'b1) ready_viol++;
            @(posedge clk);
            if (s_valid && rdy) sent++;
            budget--;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        start   = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int w, input int h);
        int waited;
        int got;
        logic [SW-1:0] er, eg, eb;
        check({tag, "/ready_low_after_last"}, 64'(s_ready), 64'd0);
        waited = 0;
        while (fd_total == fd_base && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "/frame_done_count"}, 64'(fd_total - fd_base), 64'd1);
        got = n_wr - wr_base;
        check({tag, "/write_count"}, 64'(got), 64'(w * h));
        for (int k = 0; k < got && k < w * h; k++) begin
            check($sformatf("%s/write%0d", tag, k), 64'(wr_key[wr_base + k]),
                  64'({AW'(k), exp_px[k]}));
        end
        if (fd_total > fd_base && got > 0) begin
            check({tag, "/frame_done_after_last_write"}, 64'(fd_cyc),
                  64'(wr_cyc[n_wr - 1] + 1));
        end
        check({tag, "/pix_cnt"},    64'(pix_cnt),  64'(w * h));
        check({tag, "/err_line"},   64'(err_line), 64'(exp_line));
        check({tag, "/err_sof"},    64'(err_sof),  64'(exp_sof));
        check({tag, "/err_cfg"},    64'(err_cfg),  64'd0);
        check({tag, "/busy_idle"},  64'(busy),     64'd0);
        check({tag, "/ready_held"}, 64'(ready_viol), 64'd0);
        er = '0; eg = '0; eb = '0;
        foreach (exp_px[k]) begin
            er += SW'(exp_px[k][23:16]);
            eg += SW'(exp_px[k][15:8]);
            eb += SW'(exp_px[k][7:0]);
        end
`ifdef RGB_FRAME_CAPTURE_CHECKSUM_EN
        check({tag, "/sum_r"}, 64'(sum_r), 64'(er));
        check({tag, "/sum_g"}, 64'(sum_g), 64'(eg));
        check({tag, "/sum_b"}, 64'(sum_b), 64'(eb));
`endif
    endtask

    task automatic run_frame(input string tag, input int w, input int h,
                             input int junk, input int gap, input int bad_eol_k,
                             input int extra_sof_k, input bit idx_data,
                             input bit poke);
        int sent;
        build_stream(w, h, junk, bad_eol_k, extra_sof_k, idx_data);
        wr_base = n_wr;
        fd_base = fd_total;
        pulse_start(w, h);
        check({tag, "/busy_after_start"},   64'(busy),    64'd1);
        check({tag, "/err_cfg_after_start"}, 64'(err_cfg), 64'd0);
        check({tag, "/pix_cnt_cleared"},    64'(pix_cnt), 64'd0);
        drive_stream(gap, stream.size(), poke, sent);
        check({tag, "/stream_accepted"}, 64'(sent), 64'(stream.size()));
        finish_frame(tag, w, h);
    endtask

    initial begin
        int sent;
        int wr0;

        rst        = 1'b1;
        start      = 1'b0;
        cfg_width  = '0;
        cfg_height = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_sof      = 1'b0;
        s_eol      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/s_ready",    64'(s_ready),    64'd0);
        check("reset/busy",       64'(busy),       64'd0);
        check("reset/mem_port",   64'({mem_we, mem_addr, mem_wdata}), 64'd0);
        check("reset/frame_done", 64'(frame_done), 64'd0);
        check("reset/errors",     64'({err_sof, err_line, err_cfg}), 64'd0);
        check("reset/pix_cnt",    64'(pix_cnt),    64'd0);

        // Basic 4x3 frame carrying its own index as data.
        run_frame("index4x3", 4, 3, 0, 0, -1, -1, 1'b1, 1'b0);
        // Junk ahead of the SOF must not reach the buffer.
        run_frame("junk4x3", 4, 3, 3, 0, -1, -1, 1'b0, 1'b0);
        // Random valid gaps; start held high mid-capture must be ignored.
        run_frame("gaps4x3", 4, 3, 2, 50, -1, -1, 1'b0, 1'b1);
        // EOL raised early at x=2 of line 1.
        run_frame("bad_eol", 4, 3, 0, 0, 6, -1, 1'b0, 1'b0);
        // SOF repeated mid-frame; the pixel is still stored as data.
        run_frame("mid_sof", 4, 3, 0, 30, -1, 9, 1'b0, 1'b0);

        // Reset after 5 pixels of a capture: no frame_done, flags cleared.
        build_stream(4, 3, 0, -1, -1, 1'b0);
        fd_base = fd_total;
        pulse_start(4, 3);
        drive_stream(0, 5, 1'b0, sent);
        check("abort/sent", 64'(sent), 64'd5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort/busy",    64'(busy),    64'd0);
        check("abort/s_ready", 64'(s_ready), 64'd0);
        check("abort/errors",  64'({err_sof, err_line, err_cfg}), 64'd0);
        check("abort/pix_cnt", 64'(pix_cnt), 64'd0);
`ifdef RGB_FRAME_CAPTURE_CHECKSUM_EN
        check("abort/sums", 64'({sum_r, sum_g, sum_b}), 64'd0);
`endif
        repeat (5) @(negedge clk);
        check("abort/no_frame_done", 64'(fd_total - fd_base), 64'd0);
        run_frame("post_abort", 4, 3, 0, 0, -1, -1, 1'b0, 1'b0);

        // Illegal configurations leave the block idle with err_cfg set.
        wr0 = n_wr;
        pulse_start(0, 3);
        check("cfg_w0/err_cfg", 64'(err_cfg), 64'd1);
        check("cfg_w0/busy",    64'(busy),    64'd0);
        repeat (4) @(negedge clk);
        check("cfg_w0/still_idle", 64'({busy, s_ready}), 64'd0);
        check("cfg_w0/no_writes",  64'(n_wr - wr0),      64'd0);
        pulse_start(W_MAX + 1, 3);
        check("cfg_wbig/err_cfg", 64'(err_cfg), 64'd1);
        pulse_start(4, H_MAX + 1);
        check("cfg_hbig/err_cfg", 64'(err_cfg), 64'd1);
        check("cfg_hbig/busy",    64'(busy),    64'd0);
        // A legal start clears err_cfg (checked inside run_frame).
        run_frame("cfg_recover", 4, 3, 0, 0, -1, -1, 1'b0, 1'b0);

        // Size boundaries: single pixel, and a full-width line.
        run_frame("one_px", 1, 1, 2, 0, -1, -1, 1'b0, 1'b0);
        run_frame("w_max", W_MAX, 1, 0, 0, -1, -1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rgb_frame_capture.md
Name: rgb_frame_capture

Overview:
- Captures one RGB frame from a valid/ready pixel stream into a flat frame-buffer memory, addressed row-major at y*W+x.
- Sits directly upstream of the image-matrix comparison stage, which reads the buffer only after frame_done.
- Checks stream framing (SOF, line length, frame length) and reports the captured pixel count.

Parameters:
- CW, 8, bits per colour channel
- W_MAX, 640, maximum frame width in pixels
- H_MAX, 480, maximum frame height in pixels
- AW, $clog2(W_MAX*H_MAX), frame-buffer address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; arms a capture
- cfg_width  in  16  frame width W, sampled on start; legal range 1..W_MAX
- cfg_height  in  16  frame height H, sampled on start; legal range 1..H_MAX
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel ready
- s_data  in  3*CW  pixel as {R,G,B}; R in the MSBs
- s_sof  in  1  first pixel of frame
- s_eol  in  1  last pixel of line
- mem_we  out  1  frame-buffer write enable
- mem_addr  out  AW  write address
- mem_wdata  out  3*CW  write data, same packing as s_data
- busy  out  1  high from accepted start until DONE is left
- frame_done  out  1  one-cycle completion pulse
- err_sof  out  1  sticky: SOF seen mid-frame
- err_line  out  1  sticky: s_eol position does not match W
- err_cfg  out  1  sticky: illegal cfg_width or cfg_height on start
- pix_cnt  out  AW+1  pixels written in the current or last frame

Behaviour:
- Reset values: all outputs 0. FSM enters IDLE. x, y and address counters cleared.
- Reset mid-capture aborts the frame immediately. No frame_done is issued. Error flags clear.
- A transfer occurs on a cycle with s_valid && s_ready.
- s_ready is a registered function of state only: 1 in WAIT_SOF and CAPTURE, 0 in all other states.
- FSM states:
  - IDLE: on start, latch W and H. If W=0, H=0, W>W_MAX or H>H_MAX: set err_cfg and stay in IDLE with busy=0. Otherwise clear err_sof, err_line, err_cfg and pix_cnt, then go to WAIT_SOF.
  - WAIT_SOF: transfers without s_sof are dropped; no write, no error. The first transfer with s_sof is written at address 0 and the FSM goes to CAPTURE.
  - CAPTURE: every transfer is written. mem_we, mem_addr and mem_wdata are registered, so the write appears 1 cycle after the transfer.
  - DONE: frame_done=1 for exactly 1 cycle, then IDLE. busy falls in the same cycle DONE is left.
- Address: mem_addr is an incrementing counter. It is never computed with a multiplier.
- Line and frame tracking:
  - x increments on each write. At x=W-1 it wraps to 0 and y increments.
  - If s_eol is not asserted exactly when x=W-1, set err_line. x and y still follow the W-based count, not s_eol.
  - s_sof asserted in CAPTURE: set err_sof. The pixel is written as normal pixel data.
- Completion: the write at x=W-1, y=H-1 is the last one. The FSM goes to DONE on the next cycle, and s_ready drops on that same cycle. No pixels are ever written beyond W*H.
- pix_cnt increments with every mem_we and holds its value after DONE.
- start is ignored while busy=1.
- A start in the same cycle as the DONE to IDLE transition is ignored.

Optional Feature:
- Macro: RGB_FRAME_CAPTURE_CHECKSUM_EN.
- When defined, adds three outputs: sum_r, sum_g and sum_b, each CW+AW bits wide. Each holds the unsigned sum of its channel over all written pixels. They are cleared on an accepted start and on rst, and are stable when frame_done pulses.
- When undefined, these ports and their adders are absent and all other behaviour is unchanged.

Test Plan:
- 4x3 frame, continuous valid, correct SOF and EOL, pixels = index i → 12 writes at addr 0..11 with data i. frame_done on the cycle after the last write. pix_cnt=12. No errors.
- 3 junk pixels before SOF, then a 4x3 frame → junk is not written. First write is at addr 0 with the SOF pixel.
- Random s_valid gaps at 50% on a 4x3 frame → same memory image as the first test. s_ready=0 only outside WAIT_SOF and CAPTURE.
- EOL asserted at x=2 on line 1 → err_line=1. Still exactly 12 writes and frame_done issued.
- start with cfg_width=0 → err_cfg=1, busy stays 0, no writes. A following legal start clears err_cfg.
- rst asserted after 5 pixels, then a new 4x3 capture → no frame_done for the aborted frame. The new frame writes from addr 0 and pix_cnt=12. With RGB_FRAME_CAPTURE_CHECKSUM_EN, sum_r equals the sum of the 12 R values of the new frame only.
